// File: rtl/lsu_mem.sv
// Load/store unit memory stage: one access at a time over a simple req/ack word bus.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module lsu_mem #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  func3;
        logic        load;
        logic [31:0] wdata;
    } req_t;

    state_t      state, state_nxt;
    req_t        cur;
    logic [CW-1:0] wait_cnt;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic        accept, illegal, f3_ok, misalign, timed_out, in_bus;
    logic [31:0] addr_lat;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept    = (state == IDLE) && req_valid && (req_load || req_store);
    assign in_bus    = (state == BUS);
    assign timed_out = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Both flags set behaves as a load, so legality keys off req_load alone
    always_comb begin
        f3_ok = 1'b0;
        if (req_load)
            f3_ok = req_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else
            f3_ok = req_func3 inside {3'b000, 3'b001, 3'b010};
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        addr_lat = req_addr;
`else
        misalign = 1'b0;
        case (req_func3[1:0])
            2'b01:   addr_lat = {req_addr[31:1], 1'b0};
            2'b10:   addr_lat = {req_addr[31:2], 2'b00};
            default: addr_lat = req_addr;
        endcase
`endif
        illegal = !f3_ok || misalign;
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (!cur.load) begin
            case (cur.func3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << cur.addr[1:0];
                    st_wdata = {4{cur.wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << {cur.addr[1], 1'b0};
                    st_wdata = {2{cur.wdata[15:0]}};
                end
                default: st_wdata = cur.wdata;
            endcase
        end
    end

    always_comb begin
        case (cur.addr[1:0])
            2'b00:   ld_byte = bus_rdata[7:0];
            2'b01:   ld_byte = bus_rdata[15:8];
            2'b10:   ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = cur.addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (cur.func3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = illegal ? RESP : BUS;
            BUS:     if (bus_ack || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            wait_cnt   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    cur        <= '{addr: addr_lat, func3: req_func3, load: req_load, wdata: req_wdata};
                    wait_cnt   <= '0;
                    rsp_data_q <= '0;
                    rsp_err_q  <= illegal;
                end
                BUS: begin
                    // ack on the last allowed cycle still wins over the timeout
                    if (bus_ack) begin
                        rsp_data_q <= cur.load ? ld_data : 32'h0;
                        rsp_err_q  <= 1'b0;
                    end else if (timed_out) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign stall     = accept || in_bus;
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_valid ? rsp_data_q : 32'h0;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign bus_req   = in_bus;
    assign bus_we    = in_bus && !cur.load;
    assign bus_addr  = in_bus ? {cur.addr[31:2], 2'b00} : 32'h0;
    assign bus_be    = in_bus ? st_be : 4'h0;
    assign bus_wdata = in_bus ? st_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_mem.sv
// Randomized scoreboard bench for lsu_mem: driver pushes expectations, a bus
// responder and a response monitor pop and compare independently.
module tb_lsu_mem;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_load, req_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, stall, rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        ack_r = 1'b0, late_ack = 1'b0;

    always #5 clk = ~clk;

    assign bus_ack = ack_r | late_ack;

    lsu_mem #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_load(req_load), .req_store(req_store),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    rsp_exp_t rq[$];
    bus_exp_t bq[$];
    int checks = 0, failures = 0, cyc = 0, resp_cnt = 0;
    int cfg_waits = TO;
    logic [31:0] cfg_rdata = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor
    rsp_exp_t m_e;
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rsp actual=rsp_valid required=no_response (cycle %0d)", cyc);
            end else begin
                m_e = rq.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(m_e.data));
                chk("rsp_err", 64'(rsp_err), 64'(m_e.err));
                chk("rsp_cycle", 64'(cyc), 64'(m_e.cyc));
            end
            resp_cnt++;
        end
    end

    // Bus responder: checks request fields, holds them constant, acks after cfg_waits
    int bus_cycle = 0;
    bus_exp_t r_b;
    logic [35:0] snap_ab;
    logic [32:0] snap_w;
    always @(negedge clk) begin
        if (bus_req) begin
            bus_cycle++;
            if (bus_cycle == 1) begin
                if (bq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_bus actual=bus_req required=no_access (cycle %0d)", cyc);
                end else begin
                    r_b = bq.pop_front();
                    chk("bus_addr", 64'(bus_addr), 64'(r_b.addr));
                    chk("bus_be", 64'(bus_be), 64'(r_b.be));
                    chk("bus_we", 64'(bus_we), 64'(r_b.we));
                    if (r_b.we) chk("bus_wdata", 64'(bus_wdata), 64'(r_b.wdata));
                end
                snap_ab = {bus_addr, bus_be};
                snap_w  = {bus_we, bus_wdata};
            end else begin
                chk("bus_hold_addr_be", 64'({bus_addr, bus_be}), 64'(snap_ab));
                chk("bus_hold_we_wdata", 64'({bus_we, bus_wdata}), 64'(snap_w));
            end
            ack_r     = (cfg_waits < TO) && (bus_cycle == cfg_waits + 1);
            bus_rdata = ack_r ? cfg_rdata : $urandom;
        end else begin
            bus_cycle = 0;
            ack_r     = ($urandom_range(0, 3) == 0);  // stray acks outside BUS
            bus_rdata = $urandom;
        end
    end

    // Reference model from the access rules; waits >= TO means the bus never acks
    function automatic void model(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int waits,
                                  output logic legal, output bus_exp_t b,
                                  output logic [31:0] data, output logic err);
        int off;
        logic [31:0] t;
        logic [7:0]  byt;
        logic [15:0] half;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
`ifdef LSU_MISALIGN_TRAP_EN
        if (f3[1:0] == 2'd1 && a[0]) legal = 1'b0;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) legal = 1'b0;
`endif
        off     = int'(a[1:0]);
        b.addr  = a & ~32'h3;
        b.we    = !ld;
        b.be    = 4'hF;
        b.wdata = 32'h0;
        if (!ld) begin
            if (f3 == 3'd0) begin
                b.be = 4'(1 << off);
                b.wdata = 32'(wd[7:0]) * 32'h01010101;
            end else if (f3 == 3'd1) begin
                b.be = 4'(3 << (2 * (off / 2)));
                b.wdata = 32'(wd[15:0]) * 32'h00010001;
            end else begin
                b.wdata = wd;
            end
        end
        t = rd >> (8 * off);
        byt = t[7:0];
        t = rd >> (16 * (off / 2));
        half = t[15:0];
        if (!legal || waits >= TO) begin
            data = 32'h0; err = 1'b1;
        end else begin
            err = 1'b0;
            if (!ld) data = 32'h0;
            else case (f3)
                3'd0: data = 32'(byt) | (byt[7] ? 32'hFFFFFF00 : 32'h0);
                3'd1: data = 32'(half) | (half[15] ? 32'hFFFF0000 : 32'h0);
                3'd4: data = 32'(byt);
                3'd5: data = 32'(half);
                default: data = rd;
            endcase
        end
    endfunction

    task automatic do_op(input logic ld_f, input logic st_f, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int waits);
        logic legal, err;
        bus_exp_t b;
        logic [31:0] d;
        rsp_exp_t e;
        int n, prev;
        model(ld_f, f3, a, wd, rd, waits, legal, b, d, err);
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'(1));
        prev = resp_cnt;
        cfg_waits = waits;
        cfg_rdata = rd;
        if (legal) bq.push_back(b);
        e.data = d;
        e.err  = err;
        e.cyc  = !legal ? cyc + 1 : (waits >= TO ? cyc + 1 + TO : cyc + 2 + waits);
        rq.push_back(e);
        req_valid = 1'b1; req_load = ld_f; req_store = st_f;
        req_func3 = f3; req_addr = a; req_wdata = wd;
        #1 chk("stall_accept", 64'(stall), 64'(1));
        @(negedge clk);
        req_valid = 1'b0; req_func3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        chk("req_ready_busy", 64'(req_ready), 64'(0));
        chk("stall_busy", 64'(stall), 64'(legal));
        n = 0;
        while (resp_cnt == prev && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (resp_cnt == prev) begin
            checks++; failures++;
            $display("FAIL rsp_timeout actual=no_rsp_valid required=rsp_valid (cycle %0d)", cyc);
            rq.delete(); bq.delete();
        end
    endtask

    task automatic do_ignore();
        @(negedge clk);
        req_valid = 1'b1; req_load = 1'b0; req_store = 1'b0;
        req_func3 = 3'($urandom); req_addr = $urandom;
        #1 chk("stall_ignored", 64'(stall), 64'(0));
        repeat (3) begin
            @(negedge clk);
            chk("ignored_ready_bus", 64'({req_ready, bus_req}), 64'(2'b10));
        end
        req_valid = 1'b0;
    endtask

    task automatic reset_mid_bus();
        logic legal, err;
        bus_exp_t b;
        logic [31:0] d;
        model(1'b1, 3'd2, 32'h6000, 32'h0, 32'h0, TO, legal, b, d, err);
        @(negedge clk);
        cfg_waits = TO;
        bq.push_back(b);
        req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0;
        req_func3 = 3'd2; req_addr = 32'h6000;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_bus_cycle1", 64'(bus_req), 64'(1));
        @(negedge clk);
        chk("rst_bus_cycle2", 64'(bus_req), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        late_ack = 1'b1;
        chk("rst_mid_outputs", 64'({bus_req, req_ready, rsp_valid, stall}), 64'(4'b0100));
        @(negedge clk);
        late_ack = 1'b0;
        repeat (4) begin
            chk("rst_after_late_ack", 64'({bus_req, rsp_valid, req_ready}), 64'(3'b001));
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
        req_func3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_flags", 64'({req_ready, stall, rsp_valid, rsp_err, bus_req, bus_we, bus_be}),
            64'(10'b10_0000_0000));
        chk("reset_data", {rsp_data, bus_addr}, 64'h0);
        chk("reset_wdata", 64'(bus_wdata), 64'h0);
        rst = 1'b0;

        do_op(1'b0, 1'b1, 3'd0, 32'h1003, 32'h000000AB, 32'h0, 0);       // SB lane 3
        do_op(1'b1, 1'b0, 3'd0, 32'h2001, 32'h0, 32'h00008000, 3);      // LB sign-ext
        do_op(1'b1, 1'b0, 3'd4, 32'h2001, 32'h0, 32'h00008000, 3);      // LBU
        do_op(1'b1, 1'b0, 3'd2, 32'h3002, 32'h0, 32'hDEADBEEF, 1);      // misaligned LW
        do_op(1'b1, 1'b0, 3'd2, 32'h4000, 32'h0, 32'h12345678, TO);     // timeout
        do_op(1'b1, 1'b0, 3'd3, 32'h4004, 32'h0, 32'h0, 0);             // illegal load f3
        do_op(1'b0, 1'b1, 3'd4, 32'h4008, 32'h55, 32'h0, 0);            // illegal store f3
        do_op(1'b1, 1'b1, 3'd1, 32'h5002, 32'h1234, 32'h80010000, TO - 1); // both flags -> LH
        do_op(1'b0, 1'b1, 3'd1, 32'h5003, 32'hCAFE, 32'h0, 2);          // SH, addr[0] forced
        do_ignore();
        reset_mid_bus();

        for (int i = 0; i < 150; i++) begin
            logic ld, st;
            int w;
            ld = 1'($urandom); st = 1'($urandom);
            w = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, TO - 1));
            if (!ld && !st) do_ignore();
            else do_op(ld, st, 3'($urandom), $urandom, $urandom, $urandom, w);
        end

        repeat (3) @(negedge clk);
        chk("rsp_queue_empty", 64'(rq.size()), 64'(0));
        chk("bus_queue_empty", 64'(bq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum bus wait cycles before a response is forced with error.
REQ-002 Reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  memory-stage op present.
REQ-006 req_load  in  1  op is a load.
REQ-007 req_store  in  1  op is a store.
REQ-008 req_func3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address from the ALU result.
REQ-010 req_wdata  in  32  store data from rs2.
REQ-011 req_ready  out  1  accepts a request.
REQ-012 stall  out  1  freezes upstream pipeline registers.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_data  out  32  extended load data to write-back, 0 for stores.
REQ-015 rsp_err  out  1  misaligned, illegal func3 or timeout.
REQ-016 bus_req / bus_we  out  1 each  bus request, write enable.
REQ-017 bus_addr  out  32  word address, bits [1:0]=00.
REQ-018 bus_be  out  4  byte enables.
REQ-019 bus_wdata  out  32  lane-replicated store data.
REQ-020 bus_ack  in  1  transfer done; bus_rdata valid with it.
REQ-021 bus_rdata  in  32  read word.

Function
REQ-022 FSM states SHALL be IDLE, BUS and RESP.
REQ-023 req_ready SHALL be 1 exactly in IDLE.
REQ-024 Accept condition: IDLE & req_valid & (req_load|req_store); req_valid with neither flag SHALL be ignored; both flags set SHALL be treated as a load.
REQ-025 On accept, addr, func3, op and wdata SHALL be latched; next state BUS, or RESP with rsp_err=1 if the access is illegal (REQ-034, REQ-036).
REQ-026 In BUS, bus_req SHALL be held high with constant outputs until bus_ack; ack in the first BUS cycle is legal (zero wait).
REQ-027 On bus_ack, load data SHALL be extracted and registered; next state RESP.
REQ-028 A wait counter SHALL start at 0 on entry to BUS; at TIMEOUT_CYCLES with no ack, go to RESP with rsp_err=1, rsp_data=0, and drop bus_req.
REQ-029 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; minimum latency is accept-edge +2 cycles to rsp_valid.
REQ-030 stall = (IDLE & accept condition) | BUS; low in RESP.
REQ-031 Store lanes: B be=0001<<addr[1:0], byte replicated x4; H be=0011<<{addr[1],0}, half replicated x2; W be=1111. Loads: be=1111, bus_we=0.
REQ-032 Load extract: B/BU lane addr[1:0]; H/HU half addr[1]; sign-extend for B/H, zero-extend for BU/HU.
REQ-033 bus_ack outside BUS SHALL be ignored.
REQ-034 func3 011/110/111 (or 1xx on stores) SHALL be illegal: no bus access.

Reset
REQ-035 At the reset edge: state IDLE, counter 0; all outputs 0 except req_ready=1. This holds even mid-BUS: bus_req drops, the pending access is discarded, and no rsp_valid is produced.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN: when defined, H with addr[0]=1 or W with addr[1:0]!=0 SHALL be illegal (RESP, rsp_err=1, no bus access). When undefined, offending low address bits SHALL be forced to 0 and the access proceeds normally.

Verification
REQ-037 SB addr 0x1003, wdata 0x000000AB, ack 0 waits -> bus_addr 0x1000, be 1000, wdata 0xABABABAB, rsp_valid 2 cycles after accept.
REQ-038 LB addr 0x2001, rdata 0x0000_80_00, ack after 3 waits -> rsp_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-039 LW addr 0x3002 with LSU_MISALIGN_TRAP_EN -> no bus_req, rsp_err=1; without the macro -> bus_addr 0x3000 and normal data.
REQ-040 Load with no bus_ack, TIMEOUT_CYCLES=4 -> bus_req high 4 cycles, then rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-041 rst asserted in the 2nd BUS cycle -> bus_req 0 next cycle, no rsp_valid, req_ready=1; a late bus_ack is ignored.
